ring_counter_param: RTL and testbench

RING_COUNTER_PARAM -- requirements
Module: ring_counter_param

---
 rtl/ring_counter_param.sv | 81 ++++++++
 tb/tb_ring_counter_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_param.sv
// Parameterised ring / Johnson counter with load, direction control,
// illegal-state self-correction and a wrap pulse on return to the seed.
module ring_counter_param #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] shifted;
    logic             legal;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             err_nxt;

    function automatic logic [WIDTH-1:0] seed_of(input logic m);
        logic [WIDTH-1:0] s;
        s = '0;
        if (!m) s[0] = 1'b1;
        return s;
    endfunction

    // Johnson states are exactly those with at most one adjacent-bit boundary.
    function automatic logic is_legal(input logic [WIDTH-1:0] s, input logic m);
        int n;
        if (m) n = $countones(s[WIDTH-2:0] ^ s[WIDTH-1:1]);
        else   n = $countones(s);
        return m ? (n <= 1) : (n == 1);
    endfunction

    function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] s,
                                                  input logic m, input logic d);
        logic [WIDTH-1:0] r;
        if (!d) r = {s[WIDTH-2:0], s[WIDTH-1] ^ m};
        else    r = {s[0] ^ m, s[WIDTH-1:1]};
        return r;
    endfunction

    assign seed    = seed_of(mode);
    assign legal   = is_legal(q, mode);
    assign shifted = shift_of(q, mode, dir);

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (load) begin
            q_nxt = load_val;
        end else if (en) begin
            if (!legal) begin
                q_nxt   = seed;
                err_nxt = 1'b1;
            end else begin
                q_nxt    = shifted;
                wrap_nxt = (shifted == seed);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= seed;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench: WIDTH=4 and WIDTH=8 instances share stimulus and are
// checked against a behavioural sequence model.
module tb_ring_counter_param;

    logic        clk = 1'b0;
    logic        rst, en, mode, dir, load;
    logic [31:0] lv;
    logic [3:0]  q4;
    logic        wrap4, err4;
    logic [7:0]  q8;
    logic        wrap8, err8;

    always #5 clk = ~clk;

    ring_counter_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(lv[3:0]), .q(q4), .wrap(wrap4), .err(err4)
    );

    ring_counter_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(lv[7:0]), .q(q8), .wrap(wrap8), .err(err8)
    );

    typedef struct {
        logic [3:0] q4;
        logic       w4, e4;
        logic [7:0] q8;
        logic       w8, e8;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wrap8_cnt = 0;
    logic [31:0] m4, m8;

    function automatic logic [31:0] wmask(input int w);
        return (32'h1 << w) - 32'h1;
    endfunction

    function automatic logic [31:0] mseed(input bit md);
        return md ? 32'h0 : 32'h1;
    endfunction

    // One step of the rotating / twisted sequence, per shift rule.
    function automatic logic [31:0] mshift(input logic [31:0] s, input int w,
                                           input bit md, input bit d);
        bit fill;
        if (!d) begin
            fill = s[w-1] ^ md;
            return ((s << 1) & wmask(w)) | {31'h0, fill};
        end
        fill = s[0] ^ md;
        return (s >> 1) | (fill ? (32'h1 << (w-1)) : 32'h0);
    endfunction

    // Legal = reachable: one-hot for ring, one of the 2W states walked from seed for Johnson.
    function automatic bit mlegal(input logic [31:0] s, input int w, input bit md);
        logic [31:0] t;
        if (!md) return (s != 0) && ((s & (s - 32'h1)) == 0);
        t = 32'h0;
        for (int k = 0; k < 2*w; k++) begin
            if (t == s) return 1'b1;
            t = mshift(t, w, 1'b1, 1'b0);
        end
        return 1'b0;
    endfunction

    function automatic void mstep(input int w, input logic [31:0] cur,
                                  input bit r, l, e, md, d, input logic [31:0] v,
                                  output logic [31:0] nxt, output bit wr, output bit er);
        wr = 1'b0; er = 1'b0; nxt = cur;
        if (r)               nxt = mseed(md);
        else if (l)          nxt = v & wmask(w);
        else if (e) begin
            if (!mlegal(cur, w, md)) begin
                nxt = mseed(md); er = 1'b1;
            end else begin
                nxt = mshift(cur, w, md, d);
                wr  = (nxt == mseed(md));
            end
        end
    endfunction

    task automatic drive(input bit r, l, e, md, d, input logic [31:0] v);
        exp_t        x;
        logic [31:0] n4, n8;
        bit          w4b, e4b, w8b, e8b;
        @(negedge clk);
        rst = r; load = l; en = e; mode = md; dir = d; lv = v;
        mstep(4, m4, r, l, e, md, d, v, n4, w4b, e4b);
        mstep(8, m8, r, l, e, md, d, v, n8, w8b, e8b);
        m4 = n4; m8 = n8;
        x.q4 = n4[3:0]; x.w4 = w4b; x.e4 = e4b;
        x.q8 = n8[7:0]; x.w8 = w8b; x.e8 = e8b;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                n_tests++;
                if (wrap8 === 1'b1) wrap8_cnt++;
                if (q4 !== x.q4 || wrap4 !== x.w4 || err4 !== x.e4 ||
                    q8 !== x.q8 || wrap8 !== x.w8 || err8 !== x.e8) begin
                    n_fail++;
                    $display("FAIL step%0d: q4=%b wrap4=%b err4=%b q8=%b wrap8=%b err8=%b, want q4=%b wrap4=%b err4=%b q8=%b wrap8=%b err8=%b",
                             n_tests, q4, wrap4, err4, q8, wrap8, err8,
                             x.q4, x.w4, x.e4, x.q8, x.w8, x.e8);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; lv = '0;
        m4 = '0; m8 = '0;
        repeat (2) @(posedge clk);

        // Ring up from reset, one full period
        repeat (2) drive(1, 0, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 1, 0, 0, 0);
        // Johnson up, full 2W period
        drive(1, 0, 0, 1, 0, 0);
        repeat (8) drive(0, 0, 1, 1, 0, 0);
        // Ring down, then reverse direction
        drive(1, 0, 0, 0, 1, 0);
        repeat (2) drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 0, 0, 0);
        // Illegal load corrected; illegal value held while disabled
        drive(0, 1, 0, 0, 0, 32'h6);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 32'hF);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        // Mode switch at 0111, then reset overriding load and enable
        drive(1, 0, 0, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 32'h5A);
        drive(0, 0, 1, 0, 0, 0);

        // WIDTH=8 Johnson: 16 shifts from reset give exactly one wrap
        drive(1, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        wrap8_cnt = 0;
        repeat (16) drive(0, 0, 1, 1, 0, 0);
        @(posedge clk); #2;
        n_tests++;
        if (wrap8_cnt != 1) begin
            n_fail++;
            $display("FAIL w8_wrap_count: got %0d, want 1", wrap8_cnt);
        end
        n_tests++;
        if (q8 !== 8'h00) begin
            n_fail++;
            $display("FAIL w8_final_q: got %b, want 00000000", q8);
        end

        // Randomised mix of all controls
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0) ? ~mode : mode,
                  ($urandom_range(0, 7) == 0) ? ~dir : dir,
                  $urandom());
        end

        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
